// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths and writeback-select encodings for the RISC-V pipeline
package riscv_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic RESULT_ALU = 1'b0;
    localparam logic RESULT_MEM = 1'b1;
endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed data RAM, synchronous write, combinational read gated by reset
module data_memory
    import riscv_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] WD,
    output logic [XLEN-1:0] RD
);
    logic [XLEN-1:0] mem [MEM_DEPTH] = '{default: '0};
    logic [ADDR_W-1:0] index;
    logic              unused_addr_bits;

    // Byte offset and bits above the array are dropped, so accesses wrap.
    assign index            = A[ADDR_W+1:2];
    assign unused_addr_bits = &{1'b0, A[XLEN-1:ADDR_W+2], A[1:0]};

    // Contents survive reset; only the write is blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && WE) begin
            mem[index] <= WD;
        end
    end

    assign RD = rst ? mem[index] : '0;
endmodule

// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - pipeline memory stage: data memory access and M/W pipeline register
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteM,
    input  logic                 MemWriteM,
    input  logic                 ResultSrcM,
    input  logic [REG_IDX_W-1:0] RD_M,
    input  logic [XLEN-1:0]      PCPlus4M,
    input  logic [XLEN-1:0]      WriteDataM,
    input  logic [XLEN-1:0]      ALU_ResultM,
    output logic                 RegWriteW,
    output logic                 ResultSrcW,
    output logic [REG_IDX_W-1:0] RD_W,
    output logic [XLEN-1:0]      PCPlus4W,
    output logic [XLEN-1:0]      ALU_ResultW,
    output logic [XLEN-1:0]      ReadDataW
);
    logic [XLEN-1:0] read_data_m;

    data_memory #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_data_memory (
        .clk(clk),
        .rst(rst),
        .WE (MemWriteM),
        .A  (ALU_ResultM),
        .WD (WriteDataM),
        .RD (read_data_m)
    );

    logic                 reg_write_r;
    logic                 result_src_r;
    logic [REG_IDX_W-1:0] rd_r;
    logic [XLEN-1:0]      pc_plus4_r;
    logic [XLEN-1:0]      alu_result_r;
    logic [XLEN-1:0]      read_data_r;

    // No stall or flush: the stage register captures on every edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_r  <= 1'b0;
            result_src_r <= RESULT_ALU;
            rd_r         <= '0;
            pc_plus4_r   <= '0;
            alu_result_r <= '0;
            read_data_r  <= '0;
        end else begin
            reg_write_r  <= RegWriteM;
            result_src_r <= ResultSrcM;
            rd_r         <= RD_M;
            pc_plus4_r   <= PCPlus4M;
            alu_result_r <= ALU_ResultM;
            read_data_r  <= read_data_m;
        end
    end

    assign RegWriteW   = reg_write_r;
    assign ResultSrcW  = result_src_r;
    assign RD_W        = rd_r;
    assign PCPlus4W    = pc_plus4_r;
    assign ALU_ResultW = alu_result_r;
    assign ReadDataW   = read_data_r;
endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - self-checking bench for memory_cycle against a word-array reference model
module tb_memory_cycle;
    import riscv_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        ResultSrcM = 1'b0;
    logic [4:0]  RD_M = '0;
    logic [31:0] PCPlus4M = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ALU_ResultM = '0;
    logic        RegWriteW;
    logic        ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W;
    logic [31:0] ALU_ResultW;
    logic [31:0] ReadDataW;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_mem [DEPTH];

    memory_cycle #(.MEM_DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .RD_M       (RD_M),
        .PCPlus4M   (PCPlus4M),
        .WriteDataM (WriteDataM),
        .ALU_ResultM(ALU_ResultM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RD_W       (RD_W),
        .PCPlus4W   (PCPlus4W),
        .ALU_ResultW(ALU_ResultW),
        .ReadDataW  (ReadDataW)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".regwrite"},  {31'b0, RegWriteW},  32'h0);
        check({tag, ".resultsrc"}, {31'b0, ResultSrcW}, 32'h0);
        check({tag, ".rd"},        {27'b0, RD_W},       32'h0);
        check({tag, ".pc4"},       PCPlus4W,            32'h0);
        check({tag, ".alu"},       ALU_ResultW,         32'h0);
        check({tag, ".rdata"},     ReadDataW,           32'h0);
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // One instruction through M; outputs checked one edge later against the model.
    task automatic step(input string tag, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] wd,
                        input logic [31:0] alu);
        logic [31:0] exp_read;
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
        RD_M = rd; PCPlus4M = pc; WriteDataM = wd; ALU_ResultM = alu;
        exp_read = model_mem[word_of(alu)];
        @(posedge clk);
        #1;
        if (mw) model_mem[word_of(alu)] = wd;
        check({tag, ".regwrite"},  {31'b0, RegWriteW},  {31'b0, rw});
        check({tag, ".resultsrc"}, {31'b0, ResultSrcW}, {31'b0, rs});
        check({tag, ".rd"},        {27'b0, RD_W},       {27'b0, rd});
        check({tag, ".pc4"},       PCPlus4W,            pc);
        check({tag, ".alu"},       ALU_ResultW,         alu);
        check({tag, ".rdata"},     ReadDataW,           exp_read);
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data);
        step(tag, 1'b0, 1'b1, RESULT_ALU, 5'd0, 32'h100, data, addr);
    endtask

    task automatic load(input string tag, input logic [31:0] addr);
        step(tag, 1'b1, 1'b0, RESULT_MEM, 5'd5, 32'h200, 32'h0, addr);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        // Reset held with busy inputs, including a store that must not land.
        RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd7;
        PCPlus4M = 32'h4; WriteDataM = 32'h55; ALU_ResultM = 32'h10;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_hold");
        @(negedge clk);
        rst = 1'b1;
        step("reset_release", 1'b1, 1'b0, RESULT_ALU, 5'd7, 32'h4, 32'h0, 32'h10);

        store("st_deadbeef", 32'h40, 32'hDEADBEEF);
        load("ld_deadbeef", 32'h40);
        check("ld_deadbeef.value", ReadDataW, 32'hDEADBEEF);

        store("st_lowbit", 32'h44, 32'h12345678);
        load("ld_lowbit", 32'h47);
        check("ld_lowbit.value", ReadDataW, 32'h12345678);
        store("st_wrap", 32'h1000, 32'hA5A5A5A5);
        load("ld_wrap", 32'h0);
        check("ld_wrap.value", ReadDataW, 32'hA5A5A5A5);

        store("st_w1023", 32'hFFC, 32'h0BADF00D);
        step("passthru", 1'b1, 1'b0, RESULT_ALU, 5'd31, 32'h104, 32'h77, 32'hFFFFFFFF);
        load("ld_w1023", 32'hFFC);
        check("ld_w1023.value", ReadDataW, 32'h0BADF00D);

        store("st_w2_old", 32'h8, 32'h1);
        store("st_w2_same", 32'h8, 32'h2);
        check("same_cycle.old", ReadDataW, 32'h1);
        load("ld_w2_new", 32'h8);
        check("ld_w2_new.value", ReadDataW, 32'h2);

        // Asynchronous reset between edges, with a store held on the next edge.
        store("st_cafe", 32'h20, 32'hCAFEF00D);
        RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 1'b1; RD_M = 5'd9;
        PCPlus4M = 32'h300; WriteDataM = 32'h11111111; ALU_ResultM = 32'h20;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("reset_low_edge");
        @(negedge clk);
        rst = 1'b1;
        load("ld_cafe", 32'h20);
        check("ld_cafe.value", ReadDataW, 32'hCAFEF00D);

        // Random mix concentrated on a small address window to force reuse.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
            step("rand", 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 $urandom, $urandom, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
